// File: rtl/bwidow_load_ctrl.sv
// Download sequencer for the vector-arcade core: turns HPS ioctl traffic into
// ROM writes, game-select flags, DIP switches and a core reset hold.
module bwidow_load_ctrl #(
  parameter int ROM_AW   = 16,
  parameter int ROM_SIZE = 65536,
  parameter int RST_HOLD = 4095
) (
  input  logic              clk_12,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic [ROM_AW-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              mod_bwidow,
  output logic              mod_gravitar,
  output logic              mod_lunarbat,
  output logic              mod_spacduel,
  output logic [63:0]       dip_bus,
  output logic              rom_valid,
  output logic              core_reset,
  output logic              busy
);

  localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'(RST_HOLD - 1);
  localparam logic [16:0]   CNT_MAX   = '1;
  localparam logic [16:0]   ROM_FULL  = 17'(ROM_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_ROM, S_CFG, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                cfg_game_q, cfg_game_d;
  logic                core_reset_q, busy_q;
  logic                dl_q;
  logic [ROM_AW-1:0]   dn_addr_q;
  logic [7:0]          dn_data_q;
  logic                dn_wr_q;
  logic [16:0]         rom_cnt_q;
  logic                rom_valid_q;
  logic [7:0]          pend_q;
  logic [1:0]          mod_q;
  logic [3:0]          mod_oh_q;
  logic [63:0]         dip_q;

  logic idx_rom, idx_game, idx_dip;
  logic dl_start, rom_wr, game_wr, dip_wr, rom_done, commit;

  // Write decode ignores the FSM so a strobe in the first download cycle lands.
  assign idx_rom  = (ioctl_index == 8'd0);
  assign idx_game = (ioctl_index == 8'd1);
  assign idx_dip  = (ioctl_index == 8'd254);
  assign dl_start = ioctl_download & ~dl_q;
  assign rom_wr   = ioctl_download & ioctl_wr & idx_rom & ((ioctl_addr >> ROM_AW) == '0);
  assign game_wr  = ioctl_download & ioctl_wr & idx_game;
  assign dip_wr   = ioctl_download & ioctl_wr & idx_dip & (ioctl_addr[24:3] == '0);
  assign rom_done = (state_q == S_ROM) & ~ioctl_download;
  assign commit   = (state_q == S_CFG) & ~ioctl_download & cfg_game_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cfg_game_d = cfg_game_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (ioctl_download && idx_rom) begin
          state_d = S_ROM;
        end else if (ioctl_download && (idx_game || idx_dip)) begin
          state_d    = S_CFG;
          cfg_game_d = idx_game;
        end else if (state_q == S_HOLD) begin
          if (hold_cnt_q == '0) state_d = S_IDLE;
          else                  hold_cnt_d = hold_cnt_q - CW'(1);
        end
      end
      S_ROM: begin
        if (!ioctl_download) begin
          state_d    = S_HOLD;
          hold_cnt_d = HOLD_INIT;
        end
      end
      S_CFG: begin
        if (!ioctl_download) begin
          if (cfg_game_q) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk_12) begin
    if (reset) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= HOLD_INIT;
      cfg_game_q   <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b1;
      dl_q         <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_wr_q      <= 1'b0;
      rom_cnt_q    <= '0;
      rom_valid_q  <= 1'b0;
      pend_q       <= '0;
      mod_q        <= '0;
      mod_oh_q     <= 4'b0001;
      dip_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cfg_game_q   <= cfg_game_d;
      core_reset_q <= (state_d == S_ROM) || (state_d == S_HOLD);
      busy_q       <= (state_d != S_IDLE);
      dl_q         <= ioctl_download;

      dn_wr_q <= rom_wr;
      if (rom_wr) begin
        dn_addr_q <= ioctl_addr[ROM_AW-1:0];
        dn_data_q <= ioctl_dout;
      end

      if (dl_start && idx_rom)                rom_cnt_q <= rom_wr ? 17'd1 : 17'd0;
      else if (rom_wr && rom_cnt_q != CNT_MAX) rom_cnt_q <= rom_cnt_q + 17'd1;

      if (dl_start && idx_rom) rom_valid_q <= 1'b0;
      else if (rom_done)       rom_valid_q <= (rom_cnt_q == ROM_FULL);

      // A write in the start cycle beats the reload of the committed game.
      if (game_wr)                    pend_q <= ioctl_dout;
      else if (dl_start && idx_game)  pend_q <= {6'd0, mod_q};

      if (commit && pend_q < 8'd4) begin
        mod_q    <= pend_q[1:0];
        mod_oh_q <= 4'b0001 << pend_q[1:0];
      end

      if (dip_wr) dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

  assign dn_addr      = dn_addr_q;
  assign dn_data      = dn_data_q;
  assign dn_wr        = dn_wr_q;
  assign mod_bwidow   = mod_oh_q[0];
  assign mod_gravitar = mod_oh_q[1];
  assign mod_lunarbat = mod_oh_q[2];
  assign mod_spacduel = mod_oh_q[3];
  assign dip_bus      = dip_q;
  assign rom_valid    = rom_valid_q;
  assign core_reset   = core_reset_q;
  assign busy         = busy_q;

endmodule

// File: doc/bwidow_load_ctrl.md
# bwidow_load_ctrl

Sequences all HPS `ioctl` download traffic for the vector-arcade core and turns it into three outputs:
- the ROM write port (`dn_addr`/`dn_data`/`dn_wr`) of the game top;
- the game-select flags and the DIP switch bank;
- a core reset hold that covers every ROM or game-select load.

It sits between `hps_io` and the game top in the `clk_12` domain. It replaces the ad-hoc download decoding, and it tracks whether the ROM is complete.

## Interface

Parameters:
- `ROM_AW`, 16, ROM address width forwarded to the game top.
- `ROM_SIZE`, 65536, byte count a download must deliver for the ROM to be valid.
- `RST_HOLD`, 4095, core reset hold after a ROM or game-select download ends, in cycles (≥1).

Ports:
- `clk_12`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ioctl_download`  in  1  HPS download active.
- `ioctl_wr`  in  1  one-cycle write strobe.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  write data.
- `ioctl_index`  in  8  0 = ROM, 1 = game select, 254 = DIP.
- `dn_addr`  out  ROM_AW  ROM write address.
- `dn_data`  out  8  ROM write data.
- `dn_wr`  out  1  ROM write strobe.
- `mod_bwidow`, `mod_gravitar`, `mod_lunarbat`, `mod_spacduel`  out  1 each  one-hot game select.
- `dip_bus`  out  64  DIP byte k on bits [8k+7:8k].
- `rom_valid`  out  1  last ROM download delivered exactly ROM_SIZE bytes.
- `core_reset`  out  1  reset request to the game top (active-high).
- `busy`  out  1  state ≠ IDLE.

## Operation

- **States:** IDLE, ROM, CFG, HOLD.
  - `core_reset` = (state ∈ {ROM, HOLD}).
  - `busy` = (state ≠ IDLE).
- **Reset values:**
  - State HOLD, with the counter loaded to RST_HOLD-1, so the core is held after power-up.
  - `dn_*` = 0.
  - Committed mod = 0, so `mod_bwidow` = 1 and the other mod flags = 0.
  - `dip_bus` = 0, `rom_valid` = 0, byte count = 0.
- **Transitions:**
  - IDLE or HOLD: if `ioctl_download`=1, go to ROM when index=0, CFG when index is 1 or 254, otherwise stay.
  - Another index is ignored: no state change and no writes. From HOLD it keeps counting.
  - ROM, when `ioctl_download`=0: go to HOLD and load the counter with RST_HOLD-1. `rom_valid` <= (count == ROM_SIZE).
  - CFG, when `ioctl_download`=0:
    - If the download was index 1, commit the pending mod, then go to HOLD with counter RST_HOLD-1.
    - If it was index 254, go to IDLE.
  - HOLD: decrement; go to IDLE when the counter is 0 and no download is starting.
- **Write decode:** taken directly from `ioctl_download`, `ioctl_index` and `ioctl_wr`, independent of state, so a write in the first download cycle is accepted.
  - **Index 0, addr < 2^ROM_AW:** forward to `dn_*` and increment the count, saturating at 2^17-1. Higher addresses are dropped and not counted.
  - **Index 0, first download cycle:** clear the count (a same-cycle write makes the count 1) and clear `rom_valid`.
  - **Index 1:** latch the pending mod from `ioctl_dout`; the last write wins. At commit, a pending value greater than 3 is discarded and the previous mod is kept. The pending register is reloaded from the committed value at each index-1 start.
  - **Index 254, addr[24:3]==0:** write `dip_bus` byte `addr[2:0]` immediately, with no commit. Other addresses are ignored.
- **Mid-operation:** `reset` aborts any state. It returns to the reset values, except that `dip_bus` and the committed mod are also cleared.
- **Index change without a download drop:** an index change while `ioctl_download` stays high is not expected, and the state does not change.

## Timing

- All outputs are registered.
- `dn_wr`, `dn_addr` and `dn_data` appear one cycle after `ioctl_wr`, and `dn_wr` is one cycle wide. Back-to-back strobes give back-to-back `dn_wr`.
- DIP byte update: 1-cycle latency.
- ROM start: with D the first cycle `ioctl_download`=1 (index 0), `core_reset` and `busy` are 1 from D+1.
- Download end: with L the first cycle `ioctl_download`=0 (ROM or index-1 download):
  - HOLD is entered at L+1.
  - `core_reset` is 1 through L+RST_HOLD and 0 at L+RST_HOLD+1.
  - `rom_valid` (after ROM) and the mod flags (after index 1) update at L+1.
- A download starting during HOLD aborts the hold. ROM re-enters ROM; CFG drops `core_reset` the next cycle; after the new download ends, a fresh hold is loaded.
- Out of reset, `core_reset` is 1 for RST_HOLD cycles after `reset` falls.

## Test plan

- **Power-up:** RST_HOLD=4, `reset` pulsed, no download -> `core_reset` stays 1 for 4 cycles after `reset` drops, then 0 with `busy`=0; `mod_bwidow`=1.
- **Full ROM:** index 0, 65536 writes with data = addr[7:0] -> each `dn_wr` one cycle later with matching addr/data; `core_reset` 1 from D+1 to L+4; `rom_valid`=1 at L+1.
- **Short ROM and overrange:** 100 writes plus one write at addr 0x10000 -> 100 `dn_wr` pulses, the 0x10000 write not forwarded; `rom_valid`=0.
- **Game select:** index 1, write 0x02 -> `mod_lunarbat`=1 only at L+1; 4-cycle hold. A second load with 0x07 -> `mod_lunarbat` stays 1.
- **DIPs:** index 254, writes addr 0..2 = 0x11, 0x22, 0x33 and addr 8 = 0xFF -> `dip_bus`[23:0] = 0x332211, upper bytes 0, no `core_reset`.
- **Mid-operation:** reset during a ROM download -> next cycle the outputs are at their reset values and the state is HOLD. A download restarted during HOLD -> hold aborted and the count cleared on the new start.
